// File: rtl/mem_ctrl_arbiter.sv
// mem_ctrl_arbiter: byte-serial owner of the 8-bit RAM port, shared by instruction fetch and MEM loads/stores.
// Define MEMCTRL_IO_STALL_EN to add io_buffer_full, which stalls MEM writes into the 8-byte I/O window.
module mem_ctrl_arbiter #(
   parameter int          IF_BYTES = 4,
   parameter logic [31:0] IO_BASE  = 32'h0003_0000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        if_read,
   input  logic [31:0] if_addr,
   input  logic        if_clear,
   output logic        if_done,
   output logic [31:0] if_inst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [2:0]  mem_len,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   output logic [1:0]  busy_state,
`ifdef MEMCTRL_IO_STALL_EN
   input  logic        io_buffer_full,
`endif
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr
);
   typedef enum logic [2:0] {IDLE, IF_RD, MEM_RD, MEM_WR, DONE} state_t;
   state_t      state, state_n;
   logic [2:0]  cnt, cnt_n, len, len_n, k;
   logic [1:0]  bi, busy_n;
   logic [31:0] base, base_n, wdata, wdata_n, data, data_n, wa, a_n, rd_n;
   logic [7:0]  dout_n;
   logic        wr_n, ifd_n, memd_n, if_done_q, stall;

   assign if_done = if_done_q & ~if_clear;

   // a stalled write cycle repeats the same byte, so only advance past a cycle that wrote
   always_comb begin
      k = (state == MEM_WR && ram_wr) ? cnt + 3'd1 : cnt;
      wa = (state == IDLE) ? mem_addr : base + {29'd0, k};
`ifdef MEMCTRL_IO_STALL_EN
      stall = io_buffer_full && (wa - IO_BASE) < 32'd8;
`else
      stall = 1'b0;
`endif
   end

`ifndef MEMCTRL_IO_STALL_EN
   logic unused_io;
   assign unused_io = ^IO_BASE;
`endif

   always_comb begin
      state_n = state;
      cnt_n = cnt;
      len_n = len;
      base_n = base;
      wdata_n = wdata;
      data_n = data;
      busy_n = busy_state;
      a_n = '0;
      dout_n = '0;
      wr_n = 1'b0;
      ifd_n = 1'b0;
      memd_n = 1'b0;
      rd_n = '0;
      bi = cnt[1:0] - 2'd1;
      case (state)
         IDLE: begin
            cnt_n = '0;
            data_n = '0;
            busy_n = 2'b00;
            if (mem_write) begin
               state_n = MEM_WR;
               base_n = mem_addr;
               len_n = mem_len + 3'd1;
               wdata_n = mem_wdata;
               busy_n = 2'b01;
               a_n = wa;
               dout_n = mem_wdata[7:0];
               wr_n = ~stall;
            end else if (mem_read || if_read) begin
               state_n = mem_read ? MEM_RD : IF_RD;
               base_n = mem_read ? mem_addr : if_addr;
               len_n = mem_read ? mem_len : 3'(IF_BYTES);
               busy_n = mem_read ? 2'b01 : 2'b10;
               a_n = base_n;
            end
         end
         IF_RD, MEM_RD: begin
            // ram_din trails ram_a by one cycle, so cycle cnt delivers byte cnt-1
            if (cnt != 3'd0) data_n[{bi, 3'd0} +: 8] = ram_din;
            cnt_n = cnt + 3'd1;
            if (state == IF_RD && if_clear) begin
               state_n = IDLE;
               cnt_n = '0;
               busy_n = 2'b00;
            end else if (cnt == len) begin
               state_n = DONE;
               cnt_n = '0;
               ifd_n = state == IF_RD;
               memd_n = state == MEM_RD;
               rd_n = data_n;
            end else if (cnt_n < len) a_n = base + {29'd0, cnt_n};
         end
         MEM_WR: begin
            if (ram_wr && cnt == len - 3'd1) begin
               state_n = DONE;
               cnt_n = '0;
               memd_n = 1'b1;
            end else begin
               cnt_n = k;
               a_n = wa;
               dout_n = wdata[{k[1:0], 3'd0} +: 8];
               wr_n = ~stall;
            end
         end
         DONE: begin
            state_n = IDLE;
            busy_n = 2'b00;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state <= IDLE;
         cnt <= '0;
         len <= '0;
         base <= '0;
         wdata <= '0;
         data <= '0;
         busy_state <= '0;
         ram_a <= '0;
         ram_dout <= '0;
         ram_wr <= 1'b0;
         if_done_q <= 1'b0;
         mem_done <= 1'b0;
         if_inst <= '0;
         mem_rdata <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         len <= len_n;
         base <= base_n;
         wdata <= wdata_n;
         data <= data_n;
         busy_state <= busy_n;
         ram_a <= a_n;
         ram_dout <= dout_n;
         ram_wr <= wr_n;
         if_done_q <= ifd_n;
         mem_done <= memd_n;
         if_inst <= ifd_n ? rd_n : '0;
         mem_rdata <= memd_n ? rd_n : '0;
      end
   end
endmodule

// File: tb/tb_mem_ctrl_arbiter.sv
// tb_mem_ctrl_arbiter: transaction-level reference model of the arbiter against a 1 KiB byte RAM.
module tb_mem_ctrl_arbiter;
   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        if_read = 1'b0, if_clear = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0;
   logic [2:0]  mem_len = '0;
   logic        if_done, mem_done, ram_wr;
   logic [31:0] if_inst, mem_rdata, ram_a;
   logic [1:0]  busy_state;
   logic [7:0]  ram_din, ram_dout;
   logic [7:0]  ram [0:1023];
   logic [7:0]  ref_mem [0:1023];
   logic        ld_en = 1'b0;
   logic [9:0]  ld_a = '0;
   logic [7:0]  ld_d = '0;
   int          vectors = 0, errors = 0;
`ifdef MEMCTRL_IO_STALL_EN
   logic        io_full = 1'b0;
`endif

   always #5 clk_in = ~clk_in;

   // synchronous RAM: one-cycle read latency, preload port for the bench
   always @(posedge clk_in) begin
      if (ld_en) ram[ld_a] <= ld_d;
      else if (ram_wr) ram[ram_a[9:0]] <= ram_dout;
      ram_din <= ram[ram_a[9:0]];
   end

   mem_ctrl_arbiter dut (
      .clk_in(clk_in), .rst_in(rst_in), .if_read(if_read), .if_addr(if_addr), .if_clear(if_clear),
      .if_done(if_done), .if_inst(if_inst), .mem_read(mem_read), .mem_write(mem_write),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_len(mem_len), .mem_done(mem_done),
      .mem_rdata(mem_rdata), .busy_state(busy_state),
`ifdef MEMCTRL_IO_STALL_EN
      .io_buffer_full(io_full),
`endif
      .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr)
   );

   task automatic poke(input logic [9:0] a, input logic [7:0] d);
      @(negedge clk_in);
      ld_en = 1'b1;
      ld_a = a;
      ld_d = d;
      ref_mem[a] = d;
   endtask

   task automatic test_reset();
      rst_in = 1'b1;
      repeat (2) @(negedge clk_in);
      vectors++;
      if ({if_done, mem_done, if_inst, mem_rdata, busy_state, ram_dout, ram_a, ram_wr} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h, need 0", {if_done, mem_done, if_inst, mem_rdata, busy_state, ram_dout, ram_a, ram_wr});
      end
      rst_in = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({if_done, mem_done, busy_state, ram_a, ram_wr} !== '0) begin
         errors++;
         $display("FAIL post_reset_idle: busy=%b a=%h wr=%b done=%b%b, need all 0", busy_state, ram_a, ram_wr, if_done, mem_done);
      end
   endtask

   // N-byte read (MEM load or IF fetch): done at r+N+2 with little-endian bytes from the model
   task automatic read_txn(input logic [31:0] a, input int n, input logic fetch);
      logic [31:0] exp;
      logic [1:0]  b;
      exp = '0;
      b = fetch ? 2'b10 : 2'b01;
      for (int i = 0; i < n; i++) exp[8*i +: 8] = ref_mem[10'(a + 32'(i))];
      if (fetch) begin
         if_read = 1'b1;
         if_addr = a;
      end else begin
         mem_read = 1'b1;
         mem_addr = a;
         mem_len = 3'(n);
      end
      for (int c = 1; c <= n + 2; c++) begin
         @(negedge clk_in);
         vectors++;
         if (busy_state !== b || ram_wr !== 1'b0 || (c <= n && ram_a !== a + 32'(c - 1))) begin
            errors++;
            $display("FAIL read_bus a=%h c=%0d: busy=%b wr=%b ram_a=%h, need busy=%b wr=0 ram_a=%h", a, c, busy_state, ram_wr, ram_a, b, a + 32'(c - 1));
         end
         vectors++;
         if ({if_done, mem_done} !== ((c == n + 2) ? {fetch, ~fetch} : 2'b00)) begin
            errors++;
            $display("FAIL read_done a=%h c=%0d: if_done/mem_done=%b%b, need %b", a, c, if_done, mem_done, (c == n + 2) ? {fetch, ~fetch} : 2'b00);
         end
      end
      vectors++;
      if ((fetch ? if_inst : mem_rdata) !== exp) begin
         errors++;
         $display("FAIL read_data a=%h n=%0d fetch=%b: got %h, need %h", a, n, fetch, fetch ? if_inst : mem_rdata, exp);
      end
      if_read = 1'b0;
      mem_read = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({busy_state, ram_a, ram_dout, ram_wr, if_done, mem_done} !== '0) begin
         errors++;
         $display("FAIL read_idle a=%h: busy=%b ram_a=%h dout=%h wr=%b, need 0", a, busy_state, ram_a, ram_dout, ram_wr);
      end
   endtask

   // N-byte store: byte i written in cycle i, done at r+N+1
   task automatic write_txn(input logic [31:0] a, input int n, input logic [31:0] d);
      mem_write = 1'b1;
      mem_addr = a;
      mem_wdata = d;
      mem_len = 3'(n - 1);
      for (int c = 1; c <= n + 1; c++) begin
         @(negedge clk_in);
         vectors++;
         if (c <= n && {busy_state, ram_wr, ram_a, ram_dout, mem_done} !== {2'b01, 1'b1, a + 32'(c - 1), d[8*(c-1) +: 8], 1'b0}) begin
            errors++;
            $display("FAIL write_bus a=%h c=%0d: busy=%b wr=%b ram_a=%h dout=%h done=%b, need 01 1 %h %h 0", a, c, busy_state, ram_wr, ram_a, ram_dout, mem_done, a + 32'(c - 1), d[8*(c-1) +: 8]);
         end
         if (c == n + 1 && {busy_state, ram_wr, mem_done, if_done} !== 5'b01010) begin
            errors++;
            $display("FAIL write_done a=%h: busy=%b wr=%b mem_done=%b if_done=%b, need 01 0 1 0", a, busy_state, ram_wr, mem_done, if_done);
         end
      end
      for (int i = 0; i < n; i++) ref_mem[10'(a + 32'(i))] = d[8*i +: 8];
      mem_write = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({busy_state, ram_a, ram_dout, ram_wr, mem_done} !== '0) begin
         errors++;
         $display("FAIL write_idle a=%h: busy=%b ram_a=%h dout=%h wr=%b done=%b, need 0", a, busy_state, ram_a, ram_dout, ram_wr, mem_done);
      end
   endtask

   // IF and an LH arrive together: MEM goes first, IF is granted from the following IDLE
   task automatic test_priority();
      logic [31:0] word0;
      word0 = {ref_mem[3], ref_mem[2], ref_mem[1], ref_mem[0]};
      if_read = 1'b1;
      if_addr = 32'h0;
      mem_read = 1'b1;
      mem_addr = 32'h200;
      mem_len = 3'd2;
      for (int c = 1; c <= 12; c++) begin
         logic [1:0] eb, ed;
         @(negedge clk_in);
         eb = (c <= 4) ? 2'b01 : (c >= 6 && c <= 11) ? 2'b10 : 2'b00;
         ed = (c == 4) ? 2'b01 : (c == 11) ? 2'b10 : 2'b00;
         vectors++;
         if (busy_state !== eb || {if_done, mem_done} !== ed) begin
            errors++;
            $display("FAIL prio_state c=%0d: busy=%b done=%b%b, need busy=%b done=%b", c, busy_state, if_done, mem_done, eb, ed);
         end
         if (c <= 2 || (c >= 6 && c <= 9)) begin
            vectors++;
            if (ram_a !== ((c <= 2) ? 32'h200 + 32'(c - 1) : 32'(c - 6))) begin
               errors++;
               $display("FAIL prio_addr c=%0d: ram_a=%h, need %h", c, ram_a, (c <= 2) ? 32'h200 + 32'(c - 1) : 32'(c - 6));
            end
         end
         if (c == 4) begin
            vectors++;
            if (mem_rdata !== 32'h0000_1234) begin
               errors++;
               $display("FAIL prio_lh_data: got %h, need 00001234", mem_rdata);
            end
            mem_read = 1'b0;
         end
         if (c == 11) begin
            vectors++;
            if (if_inst !== word0) begin
               errors++;
               $display("FAIL prio_if_data: got %h, need %h", if_inst, word0);
            end
            if_read = 1'b0;
         end
      end
   endtask

   task automatic test_clear();
      if_read = 1'b1;
      if_addr = 32'h80;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk_in);
         vectors++;
         if ({busy_state, ram_a, if_done} !== {2'b10, 32'h80 + 32'(c - 1), 1'b0}) begin
            errors++;
            $display("FAIL clear_pre c=%0d: busy=%b ram_a=%h if_done=%b, need 10 %h 0", c, busy_state, ram_a, if_done, 32'h80 + 32'(c - 1));
         end
      end
      if_clear = 1'b1;
      if_read = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({busy_state, ram_a, ram_wr, if_done} !== '0) begin
         errors++;
         $display("FAIL clear_abort: busy=%b ram_a=%h wr=%b if_done=%b, need 0", busy_state, ram_a, ram_wr, if_done);
      end
      if_clear = 1'b0;
      read_txn(32'h40, 4, 1'b1);
      if_read = 1'b1;
      if_addr = 32'h44;
      repeat (6) @(negedge clk_in);
      vectors++;
      if (if_done !== 1'b1) begin
         errors++;
         $display("FAIL clear_done_pre: if_done=%b, need 1", if_done);
      end
      if_clear = 1'b1;
      #1;
      vectors++;
      if (if_done !== 1'b0) begin
         errors++;
         $display("FAIL clear_in_done: if_done=%b, need 0", if_done);
      end
      if_clear = 1'b0;
      if_read = 1'b0;
      @(negedge clk_in);
      vectors++;
      if ({busy_state, if_done} !== 3'b000) begin
         errors++;
         $display("FAIL clear_idle: busy=%b if_done=%b, need 00 0", busy_state, if_done);
      end
   endtask

   // reset while byte 1 of a word store is on the bus: bytes 2 and 3 must never land
   task automatic test_reset_mid_write();
      logic [7:0] b2, b3;
      b2 = ref_mem[10'h302];
      b3 = ref_mem[10'h303];
      mem_write = 1'b1;
      mem_addr = 32'h300;
      mem_wdata = 32'hDEAD_BEEF;
      mem_len = 3'd3;
      repeat (2) @(negedge clk_in);
      vectors++;
      if ({ram_wr, ram_a, ram_dout} !== {1'b1, 32'h301, 8'hBE}) begin
         errors++;
         $display("FAIL rstw_byte1: wr=%b ram_a=%h dout=%h, need 1 00000301 be", ram_wr, ram_a, ram_dout);
      end
      rst_in = 1'b1;
      @(negedge clk_in);
      vectors++;
      if ({if_done, mem_done, if_inst, mem_rdata, busy_state, ram_dout, ram_a, ram_wr} !== '0) begin
         errors++;
         $display("FAIL rstw_outputs: got %h, need 0", {if_done, mem_done, if_inst, mem_rdata, busy_state, ram_dout, ram_a, ram_wr});
      end
      rst_in = 1'b0;
      mem_write = 1'b0;
      @(negedge clk_in);
      ref_mem[10'h300] = 8'hEF;
      ref_mem[10'h301] = 8'hBE;
      vectors++;
      if ({ram[10'h302], ram[10'h303]} !== {b2, b3}) begin
         errors++;
         $display("FAIL rstw_untouched: ram[302..303]=%h, need %h", {ram[10'h302], ram[10'h303]}, {b2, b3});
      end
      read_txn(32'h300, 4, 1'b0);
   endtask

   task automatic test_random();
      for (int t = 0; t < 40; t++) begin
         int kind, n;
         logic [31:0] a;
         kind = $urandom_range(0, 2);
         a = 32'($urandom_range(0, 1020));
         n = 1 << $urandom_range(0, 2);
         case (kind)
            0: read_txn(a, n, 1'b0);
            1: write_txn(a, n, 32'($urandom));
            default: read_txn(a, 4, 1'b1);
         endcase
         repeat ($urandom_range(0, 2)) @(negedge clk_in);
      end
   endtask

`ifdef MEMCTRL_IO_STALL_EN
   task automatic test_io_stall();
      logic [7:0] d;
      d = 8'($urandom);
      mem_write = 1'b1;
      mem_addr = 32'h0003_0000;
      mem_wdata = {24'hFF_FFFF, d};
      mem_len = 3'd0;
      io_full = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk_in);
         vectors++;
         if (ram_wr !== (c == 4) || mem_done !== (c == 5) || (c == 4 && {ram_a, ram_dout} !== {32'h0003_0000, d})) begin
            errors++;
            $display("FAIL io_stall c=%0d: wr=%b done=%b ram_a=%h dout=%h, need wr=%b done=%b", c, ram_wr, mem_done, ram_a, ram_dout, c == 4, c == 5);
         end
         if (c == 3) io_full = 1'b0;
      end
      ref_mem[10'h0] = d;
      mem_write = 1'b0;
      @(negedge clk_in);
   endtask
`endif

   initial begin
      for (int i = 0; i < 1024; i++) poke(10'(i), 8'($urandom));
      poke(10'h100, 8'h11);
      poke(10'h101, 8'h22);
      poke(10'h102, 8'h33);
      poke(10'h103, 8'h44);
      poke(10'h200, 8'h34);
      poke(10'h201, 8'h12);
      @(negedge clk_in);
      ld_en = 1'b0;
      test_reset();
      read_txn(32'h100, 4, 1'b0);
      write_txn(32'h1A5, 1, 32'hFFFF_FFAB);
      read_txn(32'h1A4, 4, 1'b0);
      test_priority();
      test_clear();
      test_reset_mid_write();
      test_random();
`ifdef MEMCTRL_IO_STALL_EN
      test_io_stall();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule

// File: doc/mem_ctrl_arbiter.md
Name: mem_ctrl_arbiter

Overview:
- Sole owner of the 8-bit unified RAM port.
- Shares the port between instruction fetch (IF, 4-byte reads) and the MEM stage (1/2/4-byte loads and stores).
- Sequences each multi-byte access as byte-serial RAM cycles and returns a one-cycle done pulse with little-endian assembled data.
- Advertises which requester it is serving on busy_state, so MEM withholds its request while IF is being served.

Parameters:
IF_BYTES, 4, bytes per instruction fetch.
IO_BASE, 32'h0003_0000, start of the 8-byte I/O window; used only by the optional feature.

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous, active-high reset
if_read  input  1  IF fetch request, level, held until if_done
if_addr  input  32  fetch address
if_clear  input  1  pipeline flush; aborts an in-flight fetch
if_done  output  1  one-cycle fetch-complete pulse
if_inst  output  32  fetched word, valid while if_done=1
mem_read  input  1  MEM load request, level
mem_write  input  1  MEM store request, level
mem_addr  input  32  load/store address
mem_wdata  input  32  store data
mem_len  input  3  load: byte count 1/2/4; store: byte count minus 1, i.e. 0/1/3
mem_done  output  1  one-cycle load/store-complete pulse
mem_rdata  output  32  load data, zero-extended; MEM sign-extends
busy_state  output  2  bit1 = serving IF; bit0 = serving MEM
ram_din  input  8  RAM read byte
ram_dout  output  8  RAM write byte
ram_a  output  32  RAM byte address
ram_wr  output  1  1 = write cycle

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-high.
  - All outputs are registered.
  - Reset value of every output is 0. After the reset edge the FSM is in IDLE, no RAM write occurs, and no done pulse is issued.
  - Reset mid-transfer drops the transfer; remaining bytes are never written.
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration:
  - mem_write → MEM_WR.
  - Else mem_read → MEM_RD.
  - Else if_read → IF_RD.
  - MEM has fixed priority over IF. mem_read and mem_write are never both high.
- Byte addressing and RAM timing:
  - A request sampled in cycle r makes cycle r+1 transfer cycle 0.
  - ram_a = base+i in cycle i, with i counted by a 3-bit counter.
  - RAM read latency is 1 cycle: ram_din at the end of cycle i+1 holds byte i.
- Reads (N = IF_BYTES or mem_len):
  - Drive ram_a for i = 0..N-1; capture bytes at the ends of cycles 1..N.
  - Byte i goes to bits [8i+7:8i]; unused upper bytes are 0.
  - Enter DONE for cycle N+1. Read done arrives at r+N+2.
- Writes (N = mem_len+1):
  - ram_wr=1 and ram_dout = mem_wdata[8i+7:8i] in cycles 0..N-1.
  - DONE in cycle N, i.e. at r+N+1. ram_wr=0 in all other cycles.
- DONE state:
  - Pulse if_done or mem_done, with data, for exactly one cycle.
  - Requests are ignored in DONE; the requester drops or changes its request there.
  - Return to IDLE; the next grant is at the earliest one cycle later.
- busy_state: the bit for the served requester is 1 from cycle 0 through DONE inclusive; 00 in IDLE.
- Idle outputs: ram_a=0 and ram_dout=0 when IDLE.
- if_clear:
  - In IF_RD: abort, next state IDLE, ram_a=0, no if_done.
  - In the IF DONE cycle: if_done forced 0.
  - No effect on MEM transfers, which always complete.
- Request changes: a request deasserted mid-transfer does not abort it (except via if_clear); the transfer completes.

Optional Feature:
- MEMCTRL_IO_STALL_EN defined:
  - Adds input io_buffer_full (1 bit).
  - In MEM_WR, if io_buffer_full=1 and ram_a is within [IO_BASE, IO_BASE+7], that cycle has ram_wr=0 and the counter holds.
  - Resumes when io_buffer_full is low; done is delayed by the stall count.
- Undefined: no port; writes never stall.

Test Plan:
- LW 0x100 with RAM bytes 11,22,33,44, mem_read at r → ram_a 0x100..0x103 in r+1..r+4; mem_done at r+6 with mem_rdata=0x44332211; busy_state=01 during r+1..r+6.
- SB 0x1A5, mem_wdata=0xFFFFFFAB, mem_len=0 at r → r+1: ram_wr=1, ram_a=0x1A5, ram_dout=0xAB; mem_done at r+2; ram_wr=0 at r+2.
- if_read 0x0 and mem_read LH 0x200 (bytes 0x34,0x12) at r → MEM served first, mem_rdata=0x00001234 at r+4; IF granted in IDLE after, busy_state=10, if_inst equals RAM word at 0x0.
- if_clear during IF cycle 2 → next cycle IDLE, ram_a=0, no if_done; new fetch of 0x40 returns correct word 6 cycles after its request.
- rst_in during SW 0x300 (data 0xDEADBEEF) at byte 1 → next cycle all outputs 0, ram_wr=0; 0x302 and 0x303 unchanged.
- (MEMCTRL_IO_STALL_EN) SB 0x30000 with io_buffer_full high for 3 cycles → ram_wr low for 3 cycles, then one write of the byte; mem_done 3 cycles later than the unstalled case.
